// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int unsigned CNT_W = 8;

  // Width large enough to hold max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop level synchroniser for slow asynchronous status flags.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on the reference clock; retries on lock timeout.
// Optional macro PLL_SUP_LOCK_GLITCH_FILTER_EN filters short lock drops in S_RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 25000,
  parameter int unsigned STABLE_CYC       = 2500,
  parameter int unsigned MAX_RETRY        = 7,
  parameter int unsigned GLITCH_CYC       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             extlock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned MAX_A   = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MAX_B   = (STABLE_CYC > GLITCH_CYC) ? STABLE_CYC : GLITCH_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TMR_W   = cnt_width(MAX_CYC);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] RTY_LAST = CNT_W'(MAX_RETRY - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             lock_s;
  logic             run_loss;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (extlock),
    .q     (lock_s)
  );

`ifdef PLL_SUP_LOCK_GLITCH_FILTER_EN
  localparam logic [TMR_W-1:0] GL_LAST = TMR_W'(GLITCH_CYC - 1);

  // In S_RUN the timer counts consecutive low samples of lock_s.
  always_comb begin
    run_loss = 1'b0;
    run_loss = !lock_s && (timer == GL_LAST);
  end
`else
  always_comb begin
    run_loss = 1'b0;
    run_loss = !lock_s;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RST;
      timer         <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      case (state)
        S_RST: begin
          if (timer == RST_LAST) begin
            state   <= S_WAIT;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_WAIT: begin
          if (lock_s) begin
            state <= S_STABLE;
            timer <= '0;
          end else if (timer == TMO_LAST) begin
            timer     <= '0;
            pll_rst   <= 1'b1;
            retry_cnt <= retry_cnt + CNT_W'(1);
            if (retry_cnt == RTY_LAST) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state <= S_RST;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_STABLE: begin
          if (!lock_s) begin
            state <= S_WAIT;
            timer <= '0;
          end else if (timer == STB_LAST) begin
            state     <= S_RUN;
            timer     <= '0;
            sys_rst_n <= 1'b1;
            locked    <= 1'b1;
            retry_cnt <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_RUN: begin
          if (run_loss) begin
            state     <= S_RST;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            if (lock_loss_cnt != '1)
              lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
          end else if (lock_s) begin
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_FAIL: begin
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          locked    <= 1'b0;
          fail      <= 1'b1;
        end

        default: begin
          state     <= S_RST;
          timer     <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
